// File: rtl/fetch_buffer.sv
// fetch_buffer: PC holder, imem requester and in-order instruction FIFO.
// Optional FETCH_ILLEGAL_CHK_EN adds a per-entry illegal-encoding flag.
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [2:0]  out_imm_sel,
  output logic        out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t ONE     = cnt_t'(1);
  localparam ptr_t PONE    = ptr_t'(1);

  function automatic logic [2:0] imm_sel_f(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    unique case (1'b1)
      (op inside {7'b0010011, 7'b0000011,
                  7'b1100111, 7'b1110011}): imm_sel_f = 3'b000;
      (op == 7'b0100011):                   imm_sel_f = 3'b001;
      (op == 7'b1100011):                   imm_sel_f = 3'b010;
      (op inside {7'b0110111, 7'b0010111}): imm_sel_f = 3'b011;
      (op == 7'b1101111):                   imm_sel_f = 3'b100;
      default:                              imm_sel_f = 3'b111;
    endcase
  endfunction

  logic [31:0] pc_q, pc_d;
  logic        en_q;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;
  cnt_t        cnt_q, cnt_d;
  ptr_t        wr_q, wr_d, rd_q, rd_d;
  ptr_t        twr_q, twr_d, trd_q, trd_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] fpc_q  [DEPTH];
  logic [2:0]  sel_q  [DEPTH];
  logic [31:0] tag_q  [DEPTH];

  logic req_fire, rsp_keep, push, pop;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign imem_req_addr  = {pc_q[31:2], 2'b00};
  assign imem_req_valid = en_q && !redirect_valid &&
                          (cnt_t'(outst_q + cnt_q) < DEPTH_C);
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (drop_q == '0);
  assign push     = rsp_keep && !redirect_valid;
  assign out_valid = (cnt_q != '0);
  assign pop      = out_valid && out_ready && !redirect_valid;

  assign out_instruction = out_valid ? data_q[rd_q] : '0;
  assign out_pc          = out_valid ? fpc_q[rd_q] : '0;
  assign out_imm_sel     = out_valid ? sel_q[rd_q] : 3'b111;

`ifdef FETCH_ILLEGAL_CHK_EN
  function automatic logic illegal_f(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    illegal_f = (w[1:0] != 2'b11) ||
                !(op inside {7'b0010011, 7'b0000011, 7'b1100111,
                             7'b1110011, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111,
                             7'b0110011, 7'b0001111});
  endfunction

  logic ill_q [DEPTH];

  // Per-entry illegal flag, written alongside the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ill_q[i] <= 1'b0;
    end else if (push) begin
      ill_q[wr_q] <= illegal_f(imem_rsp_data);
    end
  end

  assign out_illegal = out_valid && ill_q[rd_q];
`else
  assign out_illegal = 1'b0;
`endif

  // Next-state for PC, counters and FIFO/tag pointers; redirect wins.
  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    twr_d   = twr_q;
    trd_d   = trd_q;
    if (req_fire)       outst_d = outst_d + ONE;
    if (imem_rsp_valid) outst_d = outst_d - ONE;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = outst_d;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      twr_d  = '0;
      trd_d  = '0;
    end else begin
      if (req_fire) begin
        pc_d  = pc_q + 32'd4;
        twr_d = twr_q + PONE;
      end
      if (imem_rsp_valid && !rsp_keep) drop_d = drop_q - ONE;
      if (push) begin
        wr_d  = wr_q + PONE;
        trd_d = trd_q + PONE;
        cnt_d = cnt_d + ONE;
      end
      if (pop) begin
        rd_d  = rd_q + PONE;
        cnt_d = cnt_d - ONE;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      en_q    <= 1'b0;
      outst_q <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      twr_q   <= '0;
      trd_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      en_q    <= 1'b1;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
    end
  end

  // Tag queue of issued addresses and instruction FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        fpc_q[i]  <= '0;
        sel_q[i]  <= 3'b111;
        tag_q[i]  <= '0;
      end
    end else begin
      if (req_fire) tag_q[twr_q] <= imem_req_addr;
      if (push) begin
        data_q[wr_q] <= imem_rsp_data;
        fpc_q[wr_q]  <= tag_q[trd_q];
        sel_q[wr_q]  <= imm_sel_f(imem_rsp_data);
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of fetch_buffer with a
// queue-based instruction memory (one-cycle response latency).
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [2:0]  out_imm_sel;
  logic        out_illegal;

  int tests = 0;
  int fails = 0;
  logic        mem_en;
  logic [31:0] pend [$];
  logic [31:0] req_log [$];

`ifdef FETCH_ILLEGAL_CHK_EN
  localparam logic ILL_ZERO = 1'b1;
`else
  localparam logic ILL_ZERO = 1'b0;
`endif

  fetch_buffer #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .out_imm_sel(out_imm_sel),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   word_at = 32'hFFF00093;
      32'h4:   word_at = 32'h00112023;
      32'h8:   word_at = 32'h00000063;
      32'hC:   word_at = 32'h12345037;
      32'h10:  word_at = 32'h000000EF;
      32'h200: word_at = 32'h00000000;
      default: word_at = {a[11:0], 20'h00013};
    endcase
  endfunction

  // Memory model: accepts requests, answers in order when enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      req_log.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_rsp_valid) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
      end
      if (mem_en && pend.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= word_at(pend[0]);
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  // Protocol: no kept response may arrive while the FIFO is full.
  always @(posedge clk) begin
    if (rst_n && imem_rsp_valid && dut.drop_q == '0 &&
        dut.cnt_q == 2'(2)) begin
      fails++;
      $error("FAIL overrun: rsp with full fifo got 1 expected 0");
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_en = 1'b0;
    #1;
    chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    step();
    step();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins,
                            input logic [2:0] sel, input logic ill);
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".ins"}, out_instruction, ins);
    chk({tag, ".sel"}, 32'(out_imm_sel), 32'(sel));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst.req_valid2", 32'(imem_req_valid), 32'd0);
    chk("rst.req_addr", imem_req_addr, 32'h0);
    chk("rst.sel", 32'(out_imm_sel), 32'h7);
    chk("rst.ins", out_instruction, 32'h0);
    chk("rst.pc", out_pc, 32'h0);
    chk("rst.ill", 32'(out_illegal), 32'd0);

    // Streaming
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    mem_en = 1'b1;
    expect_out("s0", 32'h0,  32'hFFF00093, 3'b000, 1'b0);
    expect_out("s1", 32'h4,  32'h00112023, 3'b001, 1'b0);
    expect_out("s2", 32'h8,  32'h00000063, 3'b010, 1'b0);
    expect_out("s3", 32'hC,  32'h12345037, 3'b011, 1'b0);
    expect_out("s4", 32'h10, 32'h000000EF, 3'b100, 1'b0);
    chk("s.req0", req_log[0], 32'h0);
    chk("s.req1", req_log[1], 32'h4);

    // Backpressure (reset mid-stream)
    do_reset();
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    mem_en = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("bp.nreq", 32'(req_log.size()), 32'd2);
    chk("bp.req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp.out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    expect_out("bp0", 32'h0, 32'hFFF00093, 3'b000, 1'b0);
    expect_out("bp1", 32'h4, 32'h00112023, 3'b001, 1'b0);
    expect_out("bp2", 32'h8, 32'h00000063, 3'b010, 1'b0);
    chk("bp.req2", req_log[2], 32'h8);

    // Redirect with two outstanding
    do_reset();
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rd.nreq", 32'(req_log.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("rd.req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    mem_en = 1'b1;
    chk("rd.out_valid", 32'(out_valid), 32'd0);
    expect_out("rd0", 32'h100, 32'h10000013, 3'b000, 1'b0);
    expect_out("rd1", 32'h104, 32'h10400013, 3'b000, 1'b0);
    chk("rd.req2", req_log[2], 32'h100);

    // PC wrap
    do_reset();
    rst_n = 1'b1;
    mem_en = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    expect_out("wr0", 32'hFFFF_FFFC, 32'hFFC00013, 3'b000, 1'b0);
    expect_out("wr1", 32'h0, 32'hFFF00093, 3'b000, 1'b0);
    chk("wr.req0", req_log[0], 32'hFFFF_FFFC);
    chk("wr.req1", req_log[1], 32'h0);

    // Illegal encoding
    do_reset();
    rst_n = 1'b1;
    mem_en = 1'b1;
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    expect_out("il0", 32'h200, 32'h0, 3'b111, ILL_ZERO);
    expect_out("il1", 32'h204, 32'h20400013, 3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
